// File: rtl/gap_pht_updater_if.sv
// Commit-to-updater channel: per-lane resolved branch outcomes plus the
// single ready that backpressures the whole commit group.
interface gap_pht_updater_if #(
  parameter int UPDATE_WIDTH = 2,
  parameter int PC_WIDTH     = 32,
  parameter int GHR_WIDTH    = 5
);
  logic [UPDATE_WIDTH-1:0]                upd_valid;
  logic [UPDATE_WIDTH-1:0][PC_WIDTH-1:0]  upd_pc;
  logic [UPDATE_WIDTH-1:0][GHR_WIDTH-1:0] upd_hist;
  logic [UPDATE_WIDTH-1:0]                upd_taken;
  logic                                   upd_ready;

  modport master (output upd_valid, upd_pc, upd_hist, upd_taken, input upd_ready);
  modport slave  (input upd_valid, upd_pc, upd_hist, upd_taken, output upd_ready);
endinterface

// File: rtl/gap_pht_updater.sv
// GAp PHT commit-side writer: queues resolved branches, then applies 2-bit
// saturating counter updates through a 2-stage read-modify-write.
module gap_pht_updater #(
  parameter int PHT_ENTRY_NUM = 2048,
  parameter int GHR_WIDTH     = 5,
  parameter int UPDATE_WIDTH  = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int PC_WIDTH      = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  gap_pht_updater_if.slave                   upd,
  output logic                               init_busy,
  output logic [$clog2(QUEUE_DEPTH):0]       queue_count,
  output logic                               pht_rd_en,
  output logic [$clog2(PHT_ENTRY_NUM)-1:0]   pht_rd_addr,
  input  logic [1:0]                         pht_rd_data,
  output logic                               pht_wr_en,
  output logic [$clog2(PHT_ENTRY_NUM)-1:0]   pht_wr_addr,
  output logic [1:0]                         pht_wr_data
);

  localparam int IDX_W   = $clog2(PHT_ENTRY_NUM);
  localparam int CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int PC_LO_W = IDX_W - GHR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } entry_t;

  function automatic logic [IDX_W-1:0] make_idx(input logic [PC_WIDTH-1:0]  pc,
                                                input logic [GHR_WIDTH-1:0] hist);
    return {pc[2+PC_LO_W-1:2], hist};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  state_e           state_q,  state_d;
  logic             armed_q,  armed_d;
  logic [IDX_W-1:0] sweep_q,  sweep_d;
  logic [PTR_W-1:0] wptr_q,   wptr_d;
  logic [PTR_W-1:0] rptr_q,   rptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  entry_t           mem_q [QUEUE_DEPTH];
  entry_t           mem_d [QUEUE_DEPTH];
  logic             s2_valid_q, s2_valid_d;
  logic [IDX_W-1:0] s2_idx_q,   s2_idx_d;
  logic             s2_taken_q, s2_taken_d;
  logic             fwd_valid_q, fwd_valid_d;
  logic [IDX_W-1:0] fwd_idx_q,   fwd_idx_d;
  logic [1:0]       fwd_data_q,  fwd_data_d;

  logic [PTR_W-1:0] wp;
  logic [CNT_W-1:0] enq_n;
  logic             deq;
  logic [1:0]       base_ctr;
  logic [1:0]       new_ctr;

  // Only the index bits of the PC feed the table.
  logic unused_pc;
  assign unused_pc = ^upd.upd_pc;

  assign init_busy   = (state_q == ST_INIT);
  assign queue_count = count_q;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    state_d     = state_q;
    armed_d     = 1'b1;
    sweep_d     = sweep_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    s2_valid_d  = 1'b0;
    s2_idx_d    = s2_idx_q;
    s2_taken_d  = s2_taken_q;
    fwd_valid_d = 1'b0;
    fwd_idx_d   = fwd_idx_q;
    fwd_data_d  = fwd_data_q;
    wp          = wptr_q;
    enq_n       = '0;
    deq         = 1'b0;
    base_ctr    = pht_rd_data;
    new_ctr     = 2'b00;
    upd.upd_ready = 1'b0;
    pht_rd_en   = 1'b0;
    pht_rd_addr = '0;
    pht_wr_en   = 1'b0;
    pht_wr_addr = '0;
    pht_wr_data = 2'b00;

    unique case (state_q)
      ST_INIT: begin
        // armed_q delays the first sweep write until one edge after reset release.
        if (armed_q) begin
          pht_wr_en   = 1'b1;
          pht_wr_addr = sweep_q;
          pht_wr_data = 2'b01;
          sweep_d     = sweep_q + 1'b1;
          if (sweep_q == IDX_W'(PHT_ENTRY_NUM - 1)) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        upd.upd_ready = (count_q <= CNT_W'(QUEUE_DEPTH - UPDATE_WIDTH));

        // Valid lanes pack into consecutive slots, lane 0 first.
        if (upd.upd_ready) begin
          for (int i = 0; i < UPDATE_WIDTH; i++) begin
            if (upd.upd_valid[i]) begin
              mem_d[wp] = '{idx: make_idx(upd.upd_pc[i], upd.upd_hist[i]),
                            taken: upd.upd_taken[i]};
              wp    = ptr_inc(wp);
              enq_n = enq_n + 1'b1;
            end
          end
        end
        wptr_d = wp;

        // Head comes from the registered queue, so a fresh entry waits a cycle.
        if (count_q != '0) begin
          deq         = 1'b1;
          pht_rd_en   = 1'b1;
          pht_rd_addr = mem_q[rptr_q].idx;
          s2_valid_d  = 1'b1;
          s2_idx_d    = mem_q[rptr_q].idx;
          s2_taken_d  = mem_q[rptr_q].taken;
          rptr_d      = ptr_inc(rptr_q);
        end
        count_d = count_q + enq_n - CNT_W'(deq);

        // The array returns pre-write data on a same-cycle read, so the value
        // written one cycle earlier must come from the forward register.
        if (s2_valid_q) begin
          if (fwd_valid_q && (fwd_idx_q == s2_idx_q)) base_ctr = fwd_data_q;
          new_ctr     = sat_update(base_ctr, s2_taken_q);
          pht_wr_en   = 1'b1;
          pht_wr_addr = s2_idx_q;
          pht_wr_data = new_ctr;
          fwd_valid_d = 1'b1;
          fwd_idx_d   = s2_idx_q;
          fwd_data_d  = new_ctr;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      armed_q     <= 1'b0;
      sweep_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= '0;
      s2_taken_q  <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      sweep_q     <= sweep_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      s2_valid_q  <= s2_valid_d;
      s2_idx_q    <= s2_idx_d;
      s2_taken_q  <= s2_taken_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // NOTE: queue storage is not reset; occupancy is tracked by count_q and the
  // pointers, so stale slots are never read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_gap_pht_updater.sv
// Directed bench for gap_pht_updater with a read-first PHT array model.
module tb_gap_pht_updater;

  localparam int PHT_N = 2048;
  localparam int UW    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_busy;
  logic [2:0]  queue_count;
  logic        pht_rd_en;
  logic [10:0] pht_rd_addr;
  logic [1:0]  pht_rd_data;
  logic        pht_wr_en;
  logic [10:0] pht_wr_addr;
  logic [1:0]  pht_wr_data;

  logic        poke_en;
  logic [10:0] poke_addr;
  logic [1:0]  poke_data;
  logic [1:0]  pht_mem [PHT_N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gap_pht_updater_if #(.UPDATE_WIDTH(UW), .PC_WIDTH(32), .GHR_WIDTH(5)) upd ();

  gap_pht_updater #(
    .PHT_ENTRY_NUM(PHT_N), .GHR_WIDTH(5), .UPDATE_WIDTH(UW),
    .QUEUE_DEPTH(4), .PC_WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd         (upd),
    .init_busy   (init_busy),
    .queue_count (queue_count),
    .pht_rd_en   (pht_rd_en),
    .pht_rd_addr (pht_rd_addr),
    .pht_rd_data (pht_rd_data),
    .pht_wr_en   (pht_wr_en),
    .pht_wr_addr (pht_wr_addr),
    .pht_wr_data (pht_wr_data)
  );

  // Read-first array: a same-edge read returns the old contents.
  always @(posedge clk) begin
    if (pht_rd_en) pht_rd_data <= pht_mem[pht_rd_addr];
    if (pht_wr_en) pht_mem[pht_wr_addr] <= pht_wr_data;
    if (poke_en)   pht_mem[poke_addr] <= poke_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_lanes();
    upd.upd_valid = '0;
    upd.upd_pc    = '0;
    upd.upd_hist  = '0;
    upd.upd_taken = '0;
  endtask

  task automatic drive_lane(input int lane, input logic [31:0] pc,
                            input logic [4:0] hist, input logic taken);
    upd.upd_valid[lane] = 1'b1;
    upd.upd_pc[lane]    = pc;
    upd.upd_hist[lane]  = hist;
    upd.upd_taken[lane] = taken;
  endtask

  task automatic poke(input logic [10:0] addr, input logic [1:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Called right after reset release; checks the full sweep and the RUN hand-off.
  task automatic sweep_check(input string tag);
    int w;
    int bad;
    w = 0;
    bad = 0;
    @(negedge clk);
    while (!pht_wr_en && w < 8) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_start"}, pht_wr_en, 1'b1);
    for (int a = 0; a < PHT_N; a++) begin
      if (!(pht_wr_en && pht_wr_addr == 11'(a) && pht_wr_data == 2'b01 &&
            init_busy && !upd.upd_ready && !pht_rd_en)) begin
        if (bad == 0)
          $display("FAIL %s_write a=%0d got en=%0b addr=%0h data=%0h busy=%0b",
                   tag, a, pht_wr_en, pht_wr_addr, pht_wr_data, init_busy);
        bad++;
      end
      @(negedge clk);
    end
    check({tag, "_bad_writes"}, bad, 0);
    check({tag, "_busy_fall"}, init_busy, 1'b0);
    check({tag, "_ready_rise"}, upd.upd_ready, 1'b1);
    check({tag, "_wr_idle"}, pht_wr_en, 1'b0);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  hist;
    logic        taken;
    logic [1:0]  pre;
    logic [10:0] exp_addr;
    logic [1:0]  exp_data;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [10:0] bp_addr(input int k);
    logic [5:0] kk;
    kk = 6'(k);
    return {kk, 5'b00111};
  endfunction

  initial begin
    int n_bp;
    int nxt;
    int wr_seen;
    int bad_order;
    int ready_bad;
    int max_cnt;
    int stray;

    vecs[0] = '{32'h0000_0104, 5'b10011, 1'b1, 2'b01, 11'h033, 2'b10};
    vecs[1] = '{32'h0000_0104, 5'b10011, 1'b1, 2'b11, 11'h033, 2'b11};
    vecs[2] = '{32'h0000_00FC, 5'b00000, 1'b0, 2'b00, 11'h7E0, 2'b00};
    vecs[3] = '{32'h0000_0048, 5'b11111, 1'b0, 2'b10, 11'h25F, 2'b01};
    vecs[4] = '{32'hFFFF_FF00, 5'b00101, 1'b1, 2'b00, 11'h005, 2'b01};
    vecs[5] = '{32'h1234_5678, 5'b01010, 1'b0, 2'b01, 11'h3CA, 2'b00};

    rst_n   = 1'b0;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    idle_lanes();
    repeat (3) @(negedge clk);
    check("rst_busy",  init_busy, 1'b1);
    check("rst_ready", upd.upd_ready, 1'b0);
    check("rst_count", queue_count, 3'd0);
    check("rst_wr_en", pht_wr_en, 1'b0);
    check("rst_rd_en", pht_rd_en, 1'b0);
    rst_n = 1'b1;
    sweep_check("sweep1");

    // Single-lane updates on preloaded counters.
    for (int v = 0; v < 6; v++) begin
      poke(vecs[v].exp_addr, vecs[v].pre);
      check($sformatf("v%0d_ready", v), upd.upd_ready, 1'b1);
      drive_lane(0, vecs[v].pc, vecs[v].hist, vecs[v].taken);
      @(negedge clk);
      idle_lanes();
      check($sformatf("v%0d_rd_en", v), pht_rd_en, 1'b1);
      check($sformatf("v%0d_rd_addr", v), pht_rd_addr, vecs[v].exp_addr);
      check($sformatf("v%0d_early_wr", v), pht_wr_en, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_wr_en", v), pht_wr_en, 1'b1);
      check($sformatf("v%0d_wr_addr", v), pht_wr_addr, vecs[v].exp_addr);
      check($sformatf("v%0d_wr_data", v), pht_wr_data, vecs[v].exp_data);
      @(negedge clk);
    end

    // Two lanes to the same index in one cycle: second write must use forwarded data.
    poke(11'h033, 2'b01);
    drive_lane(0, 32'h0000_0104, 5'b10011, 1'b1);
    drive_lane(1, 32'h0000_0104, 5'b10011, 1'b1);
    @(negedge clk);
    idle_lanes();
    check("dual_count", queue_count, 3'd2);
    check("dual_rd0", pht_rd_addr, 11'h033);
    @(negedge clk);
    check("dual_wr0_en", pht_wr_en, 1'b1);
    check("dual_wr0_data", pht_wr_data, 2'b10);
    check("dual_rd1_en", pht_rd_en, 1'b1);
    @(negedge clk);
    check("dual_wr1_en", pht_wr_en, 1'b1);
    check("dual_wr1_addr", pht_wr_addr, 11'h033);
    check("dual_wr1_data", pht_wr_data, 2'b11);
    @(negedge clk);
    check("dual_done", pht_wr_en, 1'b0);
    check("dual_mem", pht_mem[11'h033], 2'b11);

    // Backpressure: offer two lanes every cycle, holding them while not ready.
    n_bp = 12;
    nxt = 0;
    wr_seen = 0;
    bad_order = 0;
    ready_bad = 0;
    max_cnt = 0;
    for (int cyc = 0; cyc < 200 && wr_seen < n_bp; cyc++) begin
      @(negedge clk);
      if (int'(queue_count) > max_cnt) max_cnt = int'(queue_count);
      if (queue_count >= 3'd3 && upd.upd_ready) ready_bad++;
      if (pht_wr_en) begin
        if (wr_seen >= n_bp || pht_wr_addr != bp_addr(wr_seen) ||
            pht_wr_data != ((wr_seen % 3 != 0) ? 2'b10 : 2'b00)) begin
          if (bad_order == 0)
            $display("FAIL bp_write n=%0d got addr=%0h data=%0h", wr_seen, pht_wr_addr, pht_wr_data);
          bad_order++;
        end
        wr_seen++;
      end
      idle_lanes();
      if (nxt < n_bp) begin
        drive_lane(0, 32'(nxt << 2), 5'b00111, (nxt % 3) != 0);
        drive_lane(1, 32'((nxt + 1) << 2), 5'b00111, ((nxt + 1) % 3) != 0);
        if (upd.upd_ready) nxt += 2;
      end
    end
    idle_lanes();
    check("bp_writes", wr_seen, n_bp);
    check("bp_order", bad_order, 0);
    check("bp_ready_when_full", ready_bad, 0);
    check("bp_peak_le4", max_cnt <= 4, 1'b1);
    check("bp_peak_ge3", max_cnt >= 3, 1'b1);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (pht_wr_en || pht_rd_en) stray++;
    end
    check("bp_drained_count", queue_count, 3'd0);
    check("bp_no_extra", stray, 0);

    // Reset with three queued updates and one in the write stage.
    drive_lane(0, 32'(20 << 2), 5'b00111, 1'b1);
    drive_lane(1, 32'(21 << 2), 5'b00111, 1'b1);
    @(negedge clk);
    drive_lane(0, 32'(22 << 2), 5'b00111, 1'b1);
    drive_lane(1, 32'(23 << 2), 5'b00111, 1'b1);
    @(negedge clk);
    idle_lanes();
    check("mid_count", queue_count, 3'd3);
    check("mid_s2_wr", pht_wr_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_count", queue_count, 3'd0);
    check("mid_rst_wr_en", pht_wr_en, 1'b0);
    check("mid_rst_rd_en", pht_rd_en, 1'b0);
    check("mid_rst_ready", upd.upd_ready, 1'b0);
    check("mid_rst_busy", init_busy, 1'b1);
    check("mid_rst_addrs", {pht_wr_addr, pht_rd_addr, pht_wr_data}, 24'd0);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (pht_wr_en || pht_rd_en) stray++;
    end
    check("mid_rst_quiet", stray, 0);
    rst_n = 1'b1;
    sweep_check("sweep2");
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (pht_wr_en || pht_rd_en) stray++;
    end
    check("post_rst_no_stale", stray, 0);
    check("post_rst_count", queue_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
